// File: rtl/microsequencer_module_pkg.sv
// Shared definitions for the ASAP microsequencer: control-word bit map,
// opcode values and sequencer state encoding.
package microsequencer_module_pkg;

  localparam int CONTROL_SIGNALS = 15;

  // Control-word bit indices
  localparam int HLT = 14;
  localparam int MAI = 13;
  localparam int MI  = 12;
  localparam int MO  = 11;
  localparam int II  = 10;
  localparam int AI  = 9;
  localparam int AO  = 8;
  localparam int BI  = 7;
  localparam int BO  = 6;
  localparam int ALO = 5;
  localparam int ALS = 4;
  localparam int OUI = 3;
  localparam int PCS = 2;
  localparam int PCO = 1;
  localparam int PCI = 0;

  // Opcodes (low four opcode bits; any higher opcode bits must be zero)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } seq_state_t;

endpackage

// File: rtl/microsequencer_module_rom.sv
// Combinational microcode ROM: (opcode, step, flags) -> control word and
// a flag marking the final step of the instruction.
module microsequencer_module_rom
  import microsequencer_module_pkg::*;
#(
  parameter int OPCODE_BITS = 4,
  parameter int STEP_BITS   = 3
) (
  input  logic [OPCODE_BITS-1:0]     opcode,
  input  logic [STEP_BITS-1:0]       t_state,
  input  logic                       zf,
  input  logic                       cf,
  output logic [CONTROL_SIGNALS-1:0] ctrl,
  output logic                       last_step
);

  logic [3:0]  op;
  int unsigned step;

  // Opcodes with any bit above the low four set fall back to NOP
  always_comb begin
    op   = ((opcode >> 4) == '0) ? 4'(opcode) : OP_NOP;
    step = 32'(t_state);
  end

  // Microcode table; flags only participate in the T3 jump decision
  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (step)
      0: begin
        ctrl[PCO] = 1'b1;
        ctrl[MAI] = 1'b1;
      end
      1: begin
        ctrl[MO]  = 1'b1;
        ctrl[II]  = 1'b1;
        ctrl[PCS] = 1'b1;
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
          OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: last_step = 1'b0;
          default:                              last_step = 1'b1;
        endcase
      end
      default: begin
        case (op)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            case (step)
              2: begin
                ctrl[PCO] = 1'b1;
                ctrl[MAI] = 1'b1;
              end
              3: begin
                ctrl[MO]  = 1'b1;
                ctrl[MAI] = 1'b1;
                ctrl[PCS] = 1'b1;
              end
              4: begin
                if (op == OP_LDA) begin
                  ctrl[MO]  = 1'b1;
                  ctrl[AI]  = 1'b1;
                  last_step = 1'b1;
                end else if (op == OP_STA) begin
                  ctrl[AO]  = 1'b1;
                  ctrl[MI]  = 1'b1;
                  last_step = 1'b1;
                end else begin
                  ctrl[MO] = 1'b1;
                  ctrl[BI] = 1'b1;
                end
              end
              5: begin
                if (op == OP_ADD || op == OP_SUB) begin
                  ctrl[ALO] = 1'b1;
                  ctrl[AI]  = 1'b1;
                  ctrl[ALS] = (op == OP_SUB);
                  last_step = 1'b1;
                end
              end
              default: ;
            endcase
          end
          OP_LDI: begin
            if (step == 2) begin
              ctrl[PCO] = 1'b1;
              ctrl[MAI] = 1'b1;
            end else if (step == 3) begin
              ctrl[MO]  = 1'b1;
              ctrl[AI]  = 1'b1;
              ctrl[PCS] = 1'b1;
              last_step = 1'b1;
            end
          end
          OP_JMP, OP_JC, OP_JZ: begin
            if (step == 2) begin
              ctrl[PCO] = 1'b1;
              ctrl[MAI] = 1'b1;
            end else if (step == 3) begin
              if (op == OP_JMP || (op == OP_JC && cf) || (op == OP_JZ && zf)) begin
                ctrl[MO]  = 1'b1;
                ctrl[PCI] = 1'b1;
              end else begin
                ctrl[PCS] = 1'b1;
              end
              last_step = 1'b1;
            end
          end
          OP_OUT: begin
            if (step == 2) begin
              ctrl[AO]  = 1'b1;
              ctrl[OUI] = 1'b1;
              last_step = 1'b1;
            end
          end
          OP_HLT: begin
            if (step == 2) begin
              ctrl[HLT] = 1'b1;
              last_step = 1'b1;
            end
          end
          default: ;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/microsequencer_module.sv
// ASAP T-state microsequencer: variable-length microprograms, single-step
// support and a latched halt state left only through reset.
module microsequencer_module
  import microsequencer_module_pkg::*;
#(
  parameter int DATA_WIDTH  = 8,
  parameter int OPCODE_BITS = 4,
  parameter int STEP_BITS   = 3
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       run,
  input  logic                       step_req,
  input  logic                       zf,
  input  logic                       cf,
  input  logic [DATA_WIDTH-1:0]      ireg,
  output logic [CONTROL_SIGNALS-1:0] ctrl,
  output logic [STEP_BITS-1:0]       t_state,
  output logic                       instr_done,
  output logic                       halted
);

  seq_state_t                 state;
  logic                       adv;
  logic [OPCODE_BITS-1:0]     opcode;
  logic [CONTROL_SIGNALS-1:0] rom_ctrl;
  logic                       rom_last;
  logic                       unused_operand;

  assign opcode         = ireg[DATA_WIDTH-1 -: OPCODE_BITS];
  assign unused_operand = ^ireg[DATA_WIDTH-OPCODE_BITS-1:0];
  assign adv            = run | step_req;

  microsequencer_module_rom #(
    .OPCODE_BITS (OPCODE_BITS),
    .STEP_BITS   (STEP_BITS)
  ) u_rom (
    .opcode    (opcode),
    .t_state   (t_state),
    .zf        (zf),
    .cf        (cf),
    .ctrl      (rom_ctrl),
    .last_step (rom_last)
  );

  // Step counter and run/halt state; halt is taken on the final HLT step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_RUN;
      t_state <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (adv) begin
            if (rom_last) begin
              t_state <= '0;
              if (rom_ctrl[HLT]) state <= ST_HALT;
            end else if (t_state == '1) begin
              t_state <= '0;
            end else begin
              t_state <= t_state + 1'b1;
            end
          end
        end
        ST_HALT: t_state <= '0;
        default: begin
          state   <= ST_RUN;
          t_state <= '0;
        end
      endcase
    end
  end

  // Control word is combinational from registered state so that flags and
  // step_req act within the same cycle; reset forces it idle immediately
  always_comb begin
    ctrl       = '0;
    instr_done = 1'b0;
    if (!rst) begin
      case (state)
        ST_RUN: begin
          if (adv) begin
            ctrl       = rom_ctrl;
            instr_done = rom_last;
          end
        end
        ST_HALT: ctrl[HLT] = 1'b1;
        default: ;
      endcase
    end
  end

  // Halt indicator mirrors the state register
  always_comb halted = (state == ST_HALT);

endmodule

// File: tb/tb_microsequencer_module.sv
// Randomised scoreboard bench for microsequencer_module. The driver advances
// an instruction-level model each cycle and queues the expected outputs; the
// monitor compares them on the falling edge.
module tb_microsequencer_module;
  import microsequencer_module_pkg::*;

  localparam int CW     = CONTROL_SIGNALS;
  localparam int CYCLES = 4000;

  logic          clk = 1'b0;
  logic          rst, run, step_req, zf, cf;
  logic [7:0]    ireg;
  logic [CW-1:0] ctrl;
  logic [2:0]    t_state;
  logic          instr_done, halted;

  microsequencer_module #(
    .DATA_WIDTH  (8),
    .OPCODE_BITS (4),
    .STEP_BITS   (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .step_req   (step_req),
    .zf         (zf),
    .cf         (cf),
    .ireg       (ireg),
    .ctrl       (ctrl),
    .t_state    (t_state),
    .instr_done (instr_done),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [2:0]    t;
    logic          done;
    logic          halted;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model state: one instruction = a list of control words
  logic [CW-1:0] prog[$];
  int            jump_kind;   // 0 none, 1 carry, 2 zero
  int            step_m;
  bit            halted_m;
  bit            need_instr;
  logic [7:0]    cur_ireg;
  int            halt_cycles, halt_limit, rst_cycles;
  logic [7:0]    directed[$] = '{8'h50, 8'h70, 8'h70, 8'h20, 8'hA0, 8'h30, 8'h80,
                                 8'h80, 8'h40, 8'h10, 8'h60, 8'hE0, 8'h00, 8'hF0};

  function automatic logic [CW-1:0] w(input int a, input int b = -1, input int c = -1);
    logic [CW-1:0] r = '0;
    if (a >= 0) r[a] = 1'b1;
    if (b >= 0) r[b] = 1'b1;
    if (c >= 0) r[c] = 1'b1;
    return r;
  endfunction

  task automatic load_program(input logic [7:0] ir);
    prog = {};
    jump_kind = 0;
    prog.push_back(w(PCO, MAI));
    prog.push_back(w(MO, II, PCS));
    case (ir[7:4])
      4'h1: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, MAI, PCS)); prog.push_back(w(MO, AI)); end
      4'h2: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, MAI, PCS)); prog.push_back(w(MO, BI));
                  prog.push_back(w(ALO, AI)); end
      4'h3: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, MAI, PCS)); prog.push_back(w(MO, BI));
                  prog.push_back(w(ALO, AI, ALS)); end
      4'h4: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, MAI, PCS)); prog.push_back(w(AO, MI)); end
      4'h5: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, AI, PCS)); end
      4'h6: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, PCI)); end
      4'h7: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, PCI)); jump_kind = 1; end
      4'h8: begin prog.push_back(w(PCO, MAI)); prog.push_back(w(MO, PCI)); jump_kind = 2; end
      4'hE: prog.push_back(w(AO, OUI));
      4'hF: prog.push_back(w(HLT));
      default: ;
    endcase
  endtask

  // Driver and reference model
  initial begin
    obs_t          e;
    logic [CW-1:0] word;
    bit            last, adv, flag;
    rst = 1'b1; run = 1'b0; step_req = 1'b0; zf = 1'b0; cf = 1'b0; ireg = 8'h00;
    step_m = 0; halted_m = 0; need_instr = 1; halt_cycles = 0; halt_limit = 20;
    rst_cycles = 2;
    for (int cyc = 0; cyc < CYCLES; cyc++) begin
      @(posedge clk);
      #1;
      run      = ($urandom_range(0, 3) != 0);
      step_req = ($urandom_range(0, 4) == 0);
      zf       = 1'($urandom_range(0, 1));
      cf       = 1'($urandom_range(0, 1));
      if (!halted_m && step_m >= 2 && $urandom_range(0, 59) == 0) rst_cycles = 1;
      if (rst_cycles > 0) begin
        rst = 1'b1;
        rst_cycles--;
        ireg = 8'($urandom);
        step_m = 0; halted_m = 0; need_instr = 1; halt_cycles = 0;
        e = '{ctrl: '0, t: 3'd0, done: 1'b0, halted: 1'b0};
        exp_q.push_back(e);
        continue;
      end
      rst = 1'b0;
      if (!halted_m && need_instr) begin
        cur_ireg = (directed.size() > 0) ? directed.pop_front() : 8'($urandom);
        load_program(cur_ireg);
        need_instr = 0;
      end
      ireg = cur_ireg;
      if (halted_m) begin
        e = '{ctrl: w(HLT), t: 3'd0, done: 1'b0, halted: 1'b1};
        halt_cycles++;
        if (halt_cycles >= halt_limit) rst_cycles = 1;
      end else begin
        word = prog[step_m];
        if (step_m == 3 && jump_kind != 0) begin
          flag = (jump_kind == 1) ? cf : zf;
          if (!flag) word = w(PCS);
        end
        last = (step_m == prog.size() - 1);
        adv  = run | step_req;
        e = '{ctrl: adv ? word : '0, t: 3'(step_m), done: adv & last, halted: 1'b0};
        if (adv) begin
          if (last) begin
            step_m = 0;
            need_instr = 1;
            if (cur_ireg[7:4] == 4'hF) begin
              halted_m = 1;
              halt_cycles = 0;
              halt_limit = $urandom_range(20, 30);
            end
          end else begin
            step_m++;
          end
        end
      end
      exp_q.push_back(e);
    end
    @(negedge clk);
    #1;
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d unchecked entries, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Monitor: compare each cycle's outputs against the queued expectation
  obs_t m_exp, m_act;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_exp = exp_q.pop_front();
      m_act = '{ctrl: ctrl, t: t_state, done: instr_done, halted: halted};
      tests++;
      if (m_act !== m_exp) begin
        fails++;
        $display("FAIL cycle_obs @%0t ireg=%h run=%b step=%b rst=%b: got ctrl=%h t=%0d done=%b halted=%b, expected ctrl=%h t=%0d done=%b halted=%b",
                 $time, ireg, run, step_req, rst, m_act.ctrl, m_act.t, m_act.done, m_act.halted,
                 m_exp.ctrl, m_exp.t, m_exp.done, m_exp.halted);
      end
    end
  end

endmodule
